hazard_forward_ctrl: RTL and testbench

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

---
 rtl/hazard_forward_ctrl_pkg.sv | 17 +
 rtl/hazard_forward_ctrl_if.sv | 42 ++++
 rtl/hazard_forward_ctrl_fwd_sel.sv | 24 ++
 rtl/hazard_forward_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: FSM state type,
// forwarding select codes and the flush-length bound.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned FLUSH_CYCLES_MAX = 4;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/forwarding controller.
interface hazard_forward_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic              branch_taken;
    logic              mc_start;
    logic              mc_done;
    logic              stall;
    logic              bubble;
    logic              flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              busy;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        output branch_taken, mc_start, mc_done,
        input  stall, bubble, flush, fwd_a, fwd_b, busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        input  branch_taken, mc_start, mc_done,
        output stall, bubble, flush, fwd_a, fwd_b, busy
    );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// Per-operand forwarding select: the younger EX/MEM result beats MEM/WB; x0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_we_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush sequencing,
// multi-cycle EX wait and operand forwarding selection.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          FWD_EN       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_ctrl_if.slave  bus
);

    localparam int unsigned FC    = (FLUSH_CYCLES > FLUSH_CYCLES_MAX) ? FLUSH_CYCLES_MAX : FLUSH_CYCLES;
    localparam int unsigned CNT_W = $clog2(FC + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             stall, bubble, flush, busy;

    assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.branch_taken) begin
                    if (FC > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(FC - 1);
                    end
                end else if (bus.mc_start) begin
                    state_d = ST_MC_WAIT;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_MC_WAIT: begin
                if (bus.mc_done) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset forces every control output low regardless of the registered state.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        busy   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.branch_taken) begin
                        flush = 1'b1;
                    end else if (!bus.mc_start && load_use) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                    busy  = 1'b1;
                end
                ST_MC_WAIT: begin
                    busy   = 1'b1;
                    stall  = !bus.mc_done;
                    bubble = !bus.mc_done;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall  = stall;
    assign bus.bubble = bubble;
    assign bus.flush  = flush;
    assign bus.busy   = busy;

    generate
        if (FWD_EN) begin : g_fwd
            fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
                .rs_i     (bus.ex_rs1),
                .mem_rd_i (bus.mem_rd),
                .mem_we_i (bus.mem_reg_write),
                .wb_rd_i  (bus.wb_rd),
                .wb_we_i  (bus.wb_reg_write),
                .sel_o    (bus.fwd_a)
            );
            fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
                .rs_i     (bus.ex_rs2),
                .mem_rd_i (bus.mem_rd),
                .mem_we_i (bus.mem_reg_write),
                .wb_rd_i  (bus.wb_rd),
                .wb_we_i  (bus.wb_reg_write),
                .sel_o    (bus.fwd_b)
            );
        end else begin : g_no_fwd
            assign bus.fwd_a = FWD_RF;
            assign bus.fwd_b = FWD_RF;
        end
    endgenerate

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed plus randomized bench for hazard_forward_ctrl against a cycle-level reference model.
module tb_hazard_forward_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned FC = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_AW(AW)) bus ();

    hazard_forward_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC), .FWD_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: remaining flush cycles after the current one, and a waiting flag.
    int flush_rem = 0;
    bit waiting   = 1'b0;
    int checks    = 0;
    int passes    = 0;

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
        if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == rs) return 2'b10;
        if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_mem_read = 1'b0;
        bus.mem_rd = '0; bus.mem_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_reg_write = 1'b0;
        bus.branch_taken = 1'b0; bus.mc_start = 1'b0; bus.mc_done = 1'b0;
        rst = 1'b0;
    endtask

    // Inputs are driven just after a falling edge; outputs are checked 1ns later.
    task automatic tick(input string tag);
        logic e_stall, e_flush, e_busy, lu;
        #1;
        e_stall = 1'b0; e_flush = 1'b0; e_busy = 1'b0;
        lu = bus.ex_mem_read && bus.ex_rd != 0 &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        if (!rst) begin
            e_busy = (flush_rem > 0) || waiting;
            if (flush_rem > 0) e_flush = 1'b1;
            else if (waiting) e_stall = !bus.mc_done;
            else if (bus.branch_taken) e_flush = 1'b1;
            else if (!bus.mc_start) e_stall = lu;
        end
        chk({tag, ".stall"},  {1'b0, bus.stall},  {1'b0, e_stall});
        chk({tag, ".bubble"}, {1'b0, bus.bubble}, {1'b0, e_stall});
        chk({tag, ".flush"},  {1'b0, bus.flush},  {1'b0, e_flush});
        chk({tag, ".busy"},   {1'b0, bus.busy},   {1'b0, e_busy});
        chk({tag, ".fwd_a"},  bus.fwd_a, fwd_ref(bus.ex_rs1));
        chk({tag, ".fwd_b"},  bus.fwd_b, fwd_ref(bus.ex_rs2));
        if (rst) begin
            flush_rem = 0;
            waiting   = 1'b0;
        end else if (flush_rem > 0) begin
            flush_rem--;
        end else if (waiting) begin
            if (bus.mc_done) waiting = 1'b0;
        end else if (bus.branch_taken) begin
            flush_rem = FC - 1;
        end else if (bus.mc_start) begin
            waiting = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        bus.mem_rd = 5'd3; bus.mem_reg_write = 1'b1; bus.ex_rs1 = 5'd3;
        tick("reset0");
        tick("reset1");
        idle();

        // Load-use on rs2, then cleared
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
        tick("lu_hit");
        bus.ex_mem_read = 1'b0;
        tick("lu_clear");
        // Load to x0 never stalls
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
        tick("lu_x0");
        idle();

        // Branch pulse with a load-use hazard held through the flush window
        bus.branch_taken = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
        tick("br0");
        bus.branch_taken = 1'b0;
        tick("br1");
        bus.branch_taken = 1'b1;
        tick("br2");
        bus.branch_taken = 1'b0;
        tick("br_after");
        idle();

        // Multi-cycle op: launch, 4 waiting cycles, done
        bus.mc_start = 1'b1;
        tick("mc_launch");
        bus.mc_start = 1'b0;
        for (int i = 0; i < 4; i++) tick("mc_wait");
        bus.mc_done = 1'b1;
        tick("mc_done");
        bus.mc_done = 1'b0;
        tick("mc_after");

        // Forwarding priority and x0
        bus.mem_rd = 5'd7; bus.wb_rd = 5'd7; bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1;
        bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7;
        tick("fwd_mem");
        bus.mem_reg_write = 1'b0;
        tick("fwd_wb");
        bus.ex_rs1 = 5'd0;
        tick("fwd_x0");
        idle();

        // Reset in the second waiting cycle aborts the wait
        bus.mc_start = 1'b1;
        tick("rst_launch");
        bus.mc_start = 1'b0;
        tick("rst_wait1");
        rst = 1'b1;
        tick("rst_wait2");
        rst = 1'b0;
        bus.mc_done = 1'b1;
        tick("rst_done_ignored");
        bus.mc_done = 1'b0;
        tick("rst_after");

        // Branch and mc_start together
        bus.branch_taken = 1'b1; bus.mc_start = 1'b1;
        tick("br_mc0");
        idle();
        tick("br_mc1");
        tick("br_mc2");
        tick("br_mc3");

        // Randomized traffic over a small register range to provoke matches
        for (int n = 0; n < 400; n++) begin
            bus.id_rs1 = AW'($urandom_range(0, 7)); bus.id_rs2 = AW'($urandom_range(0, 7));
            bus.id_use_rs1 = 1'($urandom); bus.id_use_rs2 = 1'($urandom);
            bus.ex_rs1 = AW'($urandom_range(0, 7)); bus.ex_rs2 = AW'($urandom_range(0, 7));
            bus.ex_rd = AW'($urandom_range(0, 7)); bus.ex_mem_read = 1'($urandom);
            bus.mem_rd = AW'($urandom_range(0, 7)); bus.mem_reg_write = 1'($urandom);
            bus.wb_rd = AW'($urandom_range(0, 7)); bus.wb_reg_write = 1'($urandom);
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            bus.mc_start = ($urandom_range(0, 5) == 0);
            bus.mc_done = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 39) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
